// File: rtl/aes_host_load_sequencer_pkg.sv
// Shared types and default widths for the AES128 host load sequencer.
// Default widths mirror the chip-level key, block and S-box definitions.
package aes_host_load_sequencer_pkg;

  localparam int unsigned HOST_W_DEF          = 32;
  localparam int unsigned KEY_W_DEF           = 128;
  localparam int unsigned BLOCK_W_DEF         = 128;
  localparam int unsigned SBOX_W_DEF          = 2048;  // 16 x 16 table of bytes
  localparam int unsigned MAX_OUTSTANDING_DEF = 4;

  localparam int unsigned SBOX_BEATS_DEF = SBOX_W_DEF / HOST_W_DEF;
  localparam int unsigned KEY_BEATS_DEF  = KEY_W_DEF / HOST_W_DEF;
  localparam int unsigned DATA_BEATS_DEF = BLOCK_W_DEF / HOST_W_DEF;

  typedef enum logic [1:0] {
    CMD_DATA = 2'b00,
    CMD_KEY  = 2'b01,
    CMD_SBOX = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COLLECT    = 3'd1;
  localparam logic [2:0] ST_DRAIN      = 3'd2;
  localparam logic [2:0] ST_ISSUE_SBOX = 3'd3;
  localparam logic [2:0] ST_ISSUE_KEY  = 3'd4;
  localparam logic [2:0] ST_ISSUE_DATA = 3'd5;

endpackage

// File: rtl/aes_host_load_sequencer_host_word_assembler.sv
// MSB-first host word shift register with beat counter, shared by S-box, key and data transfers.
// data_nxt is the block including the word being shifted this cycle; no backpressure of its own.
module aes_host_load_sequencer_host_word_assembler
  import aes_host_load_sequencer_pkg::*;
#(
  parameter int unsigned HOST_W = HOST_W_DEF,
  parameter int unsigned SBOX_W = SBOX_W_DEF,
  parameter int unsigned LOW_W  = KEY_W_DEF,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [HOST_W-1:0] word,
  input  logic [CNT_W-1:0]  beats_m1,
  output logic              last_beat,
  output logic [SBOX_W-1:0] data_nxt,
  output logic [LOW_W-1:0]  data_low
);

  // Only the words already received are stored; the newest word comes straight from the port.
  logic [SBOX_W-HOST_W-1:0] hist_q, hist_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  assign data_nxt  = {hist_q, word};
  assign data_low  = hist_q[LOW_W-1:0];
  assign last_beat = shift_en && (cnt_q == beats_m1);

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (clr) begin
      hist_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      hist_d = data_nxt[SBOX_W-HOST_W-1:0];
      cnt_d  = last_beat ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/aes_host_load_sequencer.sv
// AES128 front end: assembles host words into S-box/key/data blocks and issues them in load order.
// Strobe one cycle after the last word; host_wready drops outside IDLE/COLLECT or at the in-flight limit.
module aes_host_load_sequencer
  import aes_host_load_sequencer_pkg::*;
#(
  parameter int unsigned HOST_W          = HOST_W_DEF,
  parameter int unsigned KEY_W           = KEY_W_DEF,
  parameter int unsigned BLOCK_W         = BLOCK_W_DEF,
  parameter int unsigned SBOX_W          = SBOX_W_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         host_cmd,
  input  logic [HOST_W-1:0]  host_wdata,
  input  logic               host_wvalid,
  output logic               host_wready,
  output logic [SBOX_W-1:0]  sbox_in,
  output logic               sbox_in_vld,
  output logic [KEY_W-1:0]   key_in,
  output logic               key_in_vld,
  output logic [BLOCK_W-1:0] data_in,
  output logic               data_in_vld,
  input  logic               data_accept,
  input  logic               data_out_vld,
  output logic               cfg_done,
  output logic               busy,
  output logic               err_seq
);

  localparam int unsigned SBOX_BEATS = SBOX_W / HOST_W;
  localparam int unsigned KEY_BEATS  = KEY_W / HOST_W;
  localparam int unsigned DATA_BEATS = BLOCK_W / HOST_W;
  localparam int unsigned CNT_W      = (SBOX_BEATS > 1) ? $clog2(SBOX_BEATS) : 1;
  localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  logic               live_q;
  logic [2:0]         state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic               xfer_err_q, xfer_err_d;
  logic               sbox_loaded_q, sbox_loaded_d;
  logic               key_loaded_q, key_loaded_d;
  logic [OUT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               err_seq_q, err_seq_d;
  logic [SBOX_W-1:0]  sbox_in_q, sbox_in_d;
  logic [KEY_W-1:0]   key_in_q, key_in_d;
  logic [BLOCK_W-1:0] data_in_q, data_in_d;

  logic               in_idle;
  logic               accept;
  logic               cmd_switch;
  logic               asm_shift;
  logic               asm_last;
  logic               new_err;
  logic               cur_err;
  logic               issue_inc;
  cmd_e               host_cmd_e;
  cmd_e               cur_cmd;
  logic [CNT_W-1:0]   beats_m1;
  logic [SBOX_W-1:0]  asm_nxt;
  logic [KEY_W-1:0]   asm_low;

  assign host_cmd_e = cmd_e'(host_cmd);
  assign in_idle    = (state_q == ST_IDLE);
  assign cur_cmd    = in_idle ? host_cmd_e : cmd_q;

  // live_q keeps host_wready low while reset is asserted and for the first edge after release.
  assign host_wready = live_q &&
                       ((state_q == ST_COLLECT) ||
                        (in_idle && !((host_cmd_e == CMD_DATA) && (out_cnt_q >= OUT_MAX))));

  assign accept     = host_wvalid && host_wready;
  assign cmd_switch = accept && (state_q == ST_COLLECT) && (host_cmd_e != cmd_q);
  assign asm_shift  = accept && !cmd_switch;

  assign new_err = (host_cmd_e == CMD_RSVD) ||
                   ((host_cmd_e == CMD_KEY) && !sbox_loaded_q) ||
                   ((host_cmd_e == CMD_DATA) && !(sbox_loaded_q && key_loaded_q));
  assign cur_err = in_idle ? new_err : xfer_err_q;

  // Reserved commands are consumed with the DATA transfer length.
  always_comb begin
    beats_m1 = CNT_W'(DATA_BEATS - 1);
    case (cur_cmd)
      CMD_SBOX: beats_m1 = CNT_W'(SBOX_BEATS - 1);
      CMD_KEY:  beats_m1 = CNT_W'(KEY_BEATS - 1);
      default:  beats_m1 = CNT_W'(DATA_BEATS - 1);
    endcase
  end

  aes_host_load_sequencer_host_word_assembler #(
    .HOST_W (HOST_W),
    .SBOX_W (SBOX_W),
    .LOW_W  (KEY_W),
    .CNT_W  (CNT_W)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cmd_switch),
    .shift_en  (asm_shift),
    .word      (host_wdata),
    .beats_m1  (beats_m1),
    .last_beat (asm_last),
    .data_nxt  (asm_nxt),
    .data_low  (asm_low)
  );

  assign issue_inc = (state_q == ST_ISSUE_DATA) && data_accept;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    xfer_err_d    = xfer_err_q;
    sbox_loaded_d = sbox_loaded_q;
    key_loaded_d  = key_loaded_q;
    out_cnt_d     = out_cnt_q;
    err_seq_d     = 1'b0;
    sbox_in_d     = sbox_in_q;
    key_in_d      = key_in_q;
    data_in_d     = data_in_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d      = host_cmd_e;
          xfer_err_d = new_err;
          state_d    = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cmd_switch) begin
          state_d   = ST_IDLE;
          err_seq_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_q == '0) state_d = ST_ISSUE_KEY;
      end
      ST_ISSUE_SBOX: begin
        state_d       = ST_IDLE;
        sbox_loaded_d = 1'b1;
        key_loaded_d  = 1'b0;
      end
      ST_ISSUE_KEY: begin
        state_d      = ST_IDLE;
        key_loaded_d = 1'b1;
      end
      ST_ISSUE_DATA: begin
        if (data_accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An errored transfer is swallowed whole and reported once, at its last word.
    if (asm_last) begin
      if (cur_err) begin
        state_d   = ST_IDLE;
        err_seq_d = 1'b1;
      end else begin
        case (cur_cmd)
          CMD_SBOX: state_d = ST_ISSUE_SBOX;
          CMD_KEY:  state_d = (out_cnt_q != '0) ? ST_DRAIN : ST_ISSUE_KEY;
          default:  state_d = ST_ISSUE_DATA;
        endcase
      end
    end

    // Output blocks only change when the matching strobe is about to rise.
    if ((state_d == ST_ISSUE_SBOX) && (state_q != ST_ISSUE_SBOX)) begin
      sbox_in_d = asm_nxt;
    end
    if ((state_d == ST_ISSUE_KEY) && (state_q != ST_ISSUE_KEY)) begin
      key_in_d = (state_q == ST_DRAIN) ? asm_low : asm_nxt[KEY_W-1:0];
    end
    if ((state_d == ST_ISSUE_DATA) && (state_q != ST_ISSUE_DATA)) begin
      data_in_d = asm_nxt[BLOCK_W-1:0];
    end

    if (issue_inc && !data_out_vld) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end else if (!issue_inc && data_out_vld) begin
      if (out_cnt_q == '0) err_seq_d = 1'b1;
      else                 out_cnt_d = out_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q        <= 1'b0;
      state_q       <= ST_IDLE;
      cmd_q         <= CMD_DATA;
      xfer_err_q    <= 1'b0;
      sbox_loaded_q <= 1'b0;
      key_loaded_q  <= 1'b0;
      out_cnt_q     <= '0;
      err_seq_q     <= 1'b0;
      sbox_in_q     <= '0;
      key_in_q      <= '0;
      data_in_q     <= '0;
    end else begin
      live_q        <= 1'b1;
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      xfer_err_q    <= xfer_err_d;
      sbox_loaded_q <= sbox_loaded_d;
      key_loaded_q  <= key_loaded_d;
      out_cnt_q     <= out_cnt_d;
      err_seq_q     <= err_seq_d;
      sbox_in_q     <= sbox_in_d;
      key_in_q      <= key_in_d;
      data_in_q     <= data_in_d;
    end
  end

  assign sbox_in     = sbox_in_q;
  assign key_in      = key_in_q;
  assign data_in     = data_in_q;
  assign sbox_in_vld = (state_q == ST_ISSUE_SBOX);
  assign key_in_vld  = (state_q == ST_ISSUE_KEY);
  assign data_in_vld = (state_q == ST_ISSUE_DATA);
  assign cfg_done    = sbox_loaded_q && key_loaded_q;
  assign busy        = (state_q != ST_IDLE) || (out_cnt_q != '0);
  assign err_seq     = err_seq_q;

endmodule

// File: tb/tb_aes_host_load_sequencer.sv
// Directed-sequence bench with randomized payloads, checked against a transaction-level model.
module tb_aes_host_load_sequencer;

  localparam logic [1:0] C_DATA = 2'b00;
  localparam logic [1:0] C_KEY  = 2'b01;
  localparam logic [1:0] C_SBOX = 2'b10;
  localparam logic [1:0] C_RSVD = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    host_cmd;
  logic [31:0]   host_wdata;
  logic          host_wvalid;
  logic          host_wready;
  logic [2047:0] sbox_in;
  logic          sbox_in_vld;
  logic [127:0]  key_in;
  logic          key_in_vld;
  logic [127:0]  data_in;
  logic          data_in_vld;
  logic          data_accept;
  logic          data_out_vld;
  logic          cfg_done;
  logic          busy;
  logic          err_seq;

  always #5 clk = ~clk;

  aes_host_load_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_cmd     (host_cmd),
    .host_wdata   (host_wdata),
    .host_wvalid  (host_wvalid),
    .host_wready  (host_wready),
    .sbox_in      (sbox_in),
    .sbox_in_vld  (sbox_in_vld),
    .key_in       (key_in),
    .key_in_vld   (key_in_vld),
    .data_in      (data_in),
    .data_in_vld  (data_in_vld),
    .data_accept  (data_accept),
    .data_out_vld (data_out_vld),
    .cfg_done     (cfg_done),
    .busy         (busy),
    .err_seq      (err_seq)
  );

  int checks = 0;
  int errors = 0;

  // Strobe activity seen on the core side.
  int n_sbox = 0, n_key = 0, n_dvld = 0, n_err = 0;
  always @(negedge clk) begin
    if (sbox_in_vld) n_sbox++;
    if (key_in_vld)  n_key++;
    if (data_in_vld) n_dvld++;
    if (err_seq)     n_err++;
  end

  // Reference model: load flags, blocks in flight, expected strobe totals.
  bit            m_sbox, m_key;
  int            m_out;
  int            exp_sbox_n = 0, exp_key_n = 0, exp_err_n = 0;
  logic [31:0]   wbuf [64];
  logic [2047:0] exp_blk;
  logic [2047:0] zero_blk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed_lo=%0h expected_lo=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) wbuf[i] = $urandom;
  endtask

  task automatic send_word(input logic [1:0] c, input logic [31:0] w);
    int t;
    t = 0;
    @(negedge clk);
    host_cmd = c; host_wdata = w; host_wvalid = 1'b1;
    #1;
    while (host_wready !== 1'b1 && t < 100) begin
      @(negedge clk); #1; t++;
    end
    check("wready", host_wready, 1);
    if (host_wready === 1'b1) @(posedge clk);
    #1;
    host_wvalid = 1'b0;
  endtask

  task automatic send_xfer(input logic [1:0] c, input int n);
    bit err;
    err = (c == C_RSVD) || (c == C_KEY && !m_sbox) || (c == C_DATA && !(m_sbox && m_key));
    exp_blk = '0;
    for (int i = 0; i < n; i++) begin
      send_word(c, wbuf[i]);
      exp_blk = {exp_blk[2015:0], wbuf[i]};
    end
    if (err) begin
      exp_err_n++;
      check("err_pulse", err_seq, 1);
      check("err_no_issue", {sbox_in_vld, key_in_vld, data_in_vld}, 0);
    end else if (c == C_SBOX) begin
      m_sbox = 1; m_key = 0; exp_sbox_n++;
      check("sbox_vld_lat", sbox_in_vld, 1);
      check_wide("sbox_val", sbox_in, exp_blk);
      @(posedge clk); #1;
      check("sbox_vld_1cyc", sbox_in_vld, 0);
    end else if (c == C_KEY) begin
      m_key = 1; exp_key_n++;
      if (m_out == 0) begin
        check("key_vld_lat", key_in_vld, 1);
        check("key_val", key_in, exp_blk[127:0]);
        @(posedge clk); #1;
        check("key_vld_1cyc", key_in_vld, 0);
        check("cfg_done", cfg_done, 1);
      end
    end else begin
      check("data_vld_lat", data_in_vld, 1);
      check("data_val", data_in, exp_blk[127:0]);
    end
  endtask

  task automatic accept_data(input int delay, input bit with_ret);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    data_accept = 1'b1; data_out_vld = with_ret;
    @(posedge clk); #1;
    data_accept = 1'b0; data_out_vld = 1'b0;
    if (!with_ret) m_out++;
  endtask

  task automatic retire();
    data_out_vld = 1'b1;
    @(posedge clk); #1;
    data_out_vld = 1'b0;
    if (m_out > 0) m_out--;
  endtask

  initial begin
    int d0;
    zero_blk = '0;
    rst_n = 1'b0; host_cmd = C_DATA; host_wdata = '0; host_wvalid = 1'b0;
    data_accept = 1'b0; data_out_vld = 1'b0;
    m_sbox = 0; m_key = 0; m_out = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wready", host_wready, 0);
    check("rst_vlds", {sbox_in_vld, key_in_vld, data_in_vld}, 0);
    check("rst_flags", {cfg_done, busy, err_seq}, 0);
    check("rst_key", key_in, 0);
    check("rst_data", data_in, 0);
    check_wide("rst_sbox", sbox_in, zero_blk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_wready", host_wready, 1);

    // Protocol errors before any configuration
    fill_rand(4); send_xfer(C_DATA, 4);
    fill_rand(4); send_xfer(C_KEY, 4);
    fill_rand(4); send_xfer(C_RSVD, 4);
    check("err_no_data", n_dvld, 0);
    fill_rand(4);
    send_word(C_SBOX, wbuf[0]);
    send_word(C_SBOX, wbuf[1]);
    send_word(C_KEY, wbuf[2]);
    exp_err_n++;
    check("switch_err", err_seq, 1);
    @(posedge clk); #1;
    check("switch_idle", busy, 0);
    check("switch_no_sbox", n_sbox, 0);

    // S-box then key
    fill_rand(64); send_xfer(C_SBOX, 64);
    check("cfg_after_sbox", cfg_done, 0);
    fill_rand(4); send_xfer(C_KEY, 4);

    // Known data block, accept held off for three cycles
    wbuf[0] = 32'h00112233; wbuf[1] = 32'h44556677;
    wbuf[2] = 32'h8899AABB; wbuf[3] = 32'hCCDDEEFF;
    d0 = n_dvld;
    send_xfer(C_DATA, 4);
    accept_data(3, 0);
    check("t2_vld_cycles", n_dvld - d0, 4);
    check("t2_vld_low", data_in_vld, 0);
    check("t2_data_hold", data_in, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    // Fill the in-flight window, then the fifth block must stall
    for (int b = 0; b < 3; b++) begin
      fill_rand(4); send_xfer(C_DATA, 4);
      accept_data($urandom_range(0, 2), 0);
    end
    @(negedge clk);
    host_cmd = C_DATA; host_wdata = $urandom; host_wvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t3_stall", host_wready, 0);
    check("t3_busy", busy, 1);
    host_wvalid = 1'b0;
    retire();
    check("t3_resume", host_wready, 1);
    fill_rand(4); send_xfer(C_DATA, 4);
    accept_data(1, 0);

    // Key reload has to wait for the core to drain
    retire(); retire();
    fill_rand(4); send_xfer(C_KEY, 4);
    check("t4_drain_wready", host_wready, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("t4_drain_hold", key_in_vld, 0);
    retire();
    check("t4_drain_one_left", key_in_vld, 0);
    retire();
    @(posedge clk); #1;
    check("t4_key_vld", key_in_vld, 1);
    check("t4_key_val", key_in, exp_blk[127:0]);
    @(posedge clk); #1;
    check("t4_key_1cyc", key_in_vld, 0);
    check("t4_idle", busy, 0);

    // Accept and retire in the same cycle leave the count alone
    fill_rand(4); send_xfer(C_DATA, 4); accept_data(0, 0);
    fill_rand(4); send_xfer(C_DATA, 4); accept_data(2, 1);
    check("t6_one_out", busy, m_out != 0);
    retire();
    check("t6_no_err", err_seq, 0);
    check("t6_zero_out", busy, 0);
    retire();
    exp_err_n++;
    check("underflow_err", err_seq, 1);
    check("underflow_busy", busy, 0);

    // Reset in the middle of an S-box load
    fill_rand(64);
    for (int i = 0; i < 30; i++) send_word(C_SBOX, wbuf[i]);
    @(negedge clk);
    host_cmd = C_SBOX; host_wdata = wbuf[30]; host_wvalid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_flags", {cfg_done, busy, host_wready}, 0);
    check("mid_rst_key", key_in, 0);
    check("mid_rst_data", data_in, 0);
    check_wide("mid_rst_sbox", sbox_in, zero_blk);
    host_wvalid = 1'b0;
    m_sbox = 0; m_key = 0; m_out = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fill_rand(64); send_xfer(C_SBOX, 64);
    fill_rand(4);  send_xfer(C_KEY, 4);
    fill_rand(4);  send_xfer(C_DATA, 4);
    accept_data(0, 0);
    retire();
    check("reload_idle", busy, 0);

    repeat (2) @(posedge clk);
    #1;
    check("total_sbox", n_sbox, exp_sbox_n);
    check("total_key", n_key, exp_key_n);
    check("total_err", n_err, exp_err_n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
